// File: rtl/wrapper_result_sink_pkg.sv
// Shared definitions for the wrapper result sink: FSM state encoding and
// default geometry of the result buffer.
package wrapper_result_sink_pkg;

    // Result buffer defaults; the frame length matches the wrapper iteration count.
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_FRAME_LEN = 4;

    // Sink controller states with fixed encodings.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } sink_state_e;

    // Writes are only accepted while a frame is being assembled.
    function automatic logic is_write_state(input sink_state_e st);
        return (st == ST_IDLE) || (st == ST_FILL);
    endfunction

endpackage

// File: rtl/wrapper_result_sink_if.sv
// Bus between the wrapper datapath / system read port (master) and the
// result sink (slave): write side, frame control, read side and status.
interface wrapper_result_sink_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) ();

    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              wr_ack;
    logic              frame_ready;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_req, wr_data, frame_done, rd_en,
        input  wr_ack, frame_ready, rd_data, rd_valid, count, overflow, underflow
    );

    modport slave (
        input  wr_req, wr_data, frame_done, rd_en,
        output wr_ack, frame_ready, rd_data, rd_valid, count, overflow, underflow
    );

endinterface

// File: rtl/wrapper_result_sink_ram.sv
// DEPTH x DATA_W register file with one write port and one registered read
// port. Storage is not reset; only the read register is.
module wrapper_result_sink_ram #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Storage write; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read word is captured on a pop and held until the next one.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Read output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/wrapper_result_sink.sv
// Write-side responder for the wrapper result path: collects a frame of
// result words, holds it, and lets a downstream reader drain it.
module wrapper_result_sink
    import wrapper_result_sink_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int FRAME_LEN = DEF_FRAME_LEN,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    wrapper_result_sink_if.slave  bus
);

    sink_state_e      state_d, state_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic             overflow_d, overflow_q;
    logic             underflow_d, underflow_q;
    logic             wr_ack_d, wr_ack_q;
    logic             rd_valid_d, rd_valid_q;
    logic             wr_ok;
    logic             rd_ok;

    // Next-state, pointer, counter and flag logic; clr overrides any access.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_ok       = 1'b0;
        rd_ok       = 1'b0;

        if (clr) begin
            state_d     = ST_IDLE;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (is_write_state(state_q)) begin
            wr_ok = bus.wr_req && (count_q < CNT_W'(DEPTH));
            if (bus.wr_req && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (bus.rd_en) begin
                underflow_d = 1'b1;
            end
            if (wr_ok) begin
                count_d  = count_q + CNT_W'(1);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if ((count_d == CNT_W'(FRAME_LEN)) || bus.frame_done) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FILL;
                end
            end else if (bus.frame_done && (state_q == ST_FILL)) begin
                state_d = (count_q == '0) ? ST_IDLE : ST_HOLD;
            end
        end else begin
            if (bus.wr_req) begin
                overflow_d = 1'b1;
            end
            rd_ok = bus.rd_en && (count_q != '0);
            if (bus.rd_en && !rd_ok) begin
                underflow_d = 1'b1;
            end
            if (rd_ok) begin
                count_d  = count_q - CNT_W'(1);
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                state_d  = (count_q == CNT_W'(1)) ? ST_IDLE : ST_DRAIN;
            end
        end

        wr_ack_d   = wr_ok;
        rd_valid_d = rd_ok;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            wr_ack_q    <= wr_ack_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    wrapper_result_sink_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (bus.rd_data)
    );

    assign bus.wr_ack      = wr_ack_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.frame_ready = (state_q == ST_HOLD);
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_wrapper_result_sink.sv
// Directed bench for the wrapper result sink: a vector table covering frame
// fill/drain, short frames, overflow, underflow and clr, plus a hand-written
// asynchronous reset sequence.
module tb_wrapper_result_sink;

    logic clk;
    logic rst_n;
    logic clr;
    int   compared;
    int   mismatched;

    wrapper_result_sink_if #(.DATA_W(8), .CNT_W(3)) bus ();

    wrapper_result_sink #(
        .DATA_W    (8),
        .DEPTH     (4),
        .FRAME_LEN (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    typedef struct {
        logic       wr_req;
        logic [7:0] wr_data;
        logic       frame_done;
        logic       rd_en;
        logic       clr;
        logic       ack;
        logic       fr;
        logic       rv;
        logic [7:0] rdat;
        logic [2:0] cnt;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic fd,
                                input logic rd, input logic cl, input logic ack,
                                input logic fr, input logic rv, input logic [7:0] rdat,
                                input logic [2:0] cnt, input logic ovf, input logic unf);
        vec_t v;
        v.wr_req = wr; v.wr_data = wd; v.frame_done = fd; v.rd_en = rd; v.clr = cl;
        v.ack = ack; v.fr = fr; v.rv = rv; v.rdat = rdat; v.cnt = cnt;
        v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ack, input logic fr, input logic rv,
                             input logic [7:0] rdat, input logic [2:0] cnt,
                             input logic ovf, input logic unf);
        check_output({tag, ".wr_ack"},      16'(bus.wr_ack),      16'(ack));
        check_output({tag, ".frame_ready"}, 16'(bus.frame_ready), 16'(fr));
        check_output({tag, ".rd_valid"},    16'(bus.rd_valid),    16'(rv));
        check_output({tag, ".rd_data"},     16'(bus.rd_data),     16'(rdat));
        check_output({tag, ".count"},       16'(bus.count),       16'(cnt));
        check_output({tag, ".overflow"},    16'(bus.overflow),    16'(ovf));
        check_output({tag, ".underflow"},   16'(bus.underflow),   16'(unf));
    endtask

    // Drive one cycle of inputs at the falling edge, then let one rising edge pass.
    task automatic apply_stimulus(input logic wr, input logic [7:0] wd, input logic fd,
                                  input logic rd, input logic cl);
        bus.wr_req     = wr;
        bus.wr_data    = wd;
        bus.frame_done = fd;
        bus.rd_en      = rd;
        clr            = cl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n          = 1'b0;
        clr            = 1'b0;
        bus.wr_req     = 1'b0;
        bus.wr_data    = 8'h00;
        bus.frame_done = 1'b0;
        bus.rd_en      = 1'b0;
        @(negedge clk);
        do_reset();
        check_all("reset_init", 0, 0, 0, 8'h00, 3'd0, 0, 0);

        // Asynchronous reset in the middle of a frame.
        apply_stimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        check_all("pre_reset", 1, 0, 0, 8'h00, 3'd2, 0, 1);
        bus.wr_req = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all("async_reset", 0, 0, 0, 8'h00, 3'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_all("post_reset", 0, 0, 0, 8'h00, 3'd0, 0, 0);
        apply_stimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        check_all("post_reset_wr", 1, 0, 0, 8'h00, 3'd1, 0, 0);
        do_reset();

        // Full frame, then drain.
        vecs.push_back(mk(1, 8'hA5, 0, 0, 0,  1, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(1, 8'h3C, 0, 0, 0,  1, 0, 0, 8'h00, 2, 0, 0));
        vecs.push_back(mk(1, 8'hFF, 0, 0, 0,  1, 0, 0, 8'h00, 3, 0, 0));
        vecs.push_back(mk(1, 8'h01, 0, 0, 0,  1, 1, 0, 8'h00, 4, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'hA5, 3, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h3C, 2, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'hFF, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h01, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h01, 0, 0, 0));
        // Short frame closed by frame_done, overflow while holding.
        vecs.push_back(mk(1, 8'h11, 0, 0, 0,  1, 0, 0, 8'h01, 1, 0, 0));
        vecs.push_back(mk(1, 8'h22, 0, 0, 0,  1, 0, 0, 8'h01, 2, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0,  0, 1, 0, 8'h01, 2, 0, 0));
        vecs.push_back(mk(1, 8'h77, 0, 0, 0,  0, 1, 0, 8'h01, 2, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h11, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h22, 0, 1, 0));
        // Underflow in IDLE and FILL, then clr.
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 0, 8'h22, 0, 1, 1));
        vecs.push_back(mk(1, 8'h33, 0, 0, 0,  1, 0, 0, 8'h22, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 0, 8'h22, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 0, 0, 8'h22, 0, 0, 0));
        // clr in the middle of a drain discards the rest of the frame.
        vecs.push_back(mk(1, 8'h41, 0, 0, 0,  1, 0, 0, 8'h22, 1, 0, 0));
        vecs.push_back(mk(1, 8'h42, 0, 0, 0,  1, 0, 0, 8'h22, 2, 0, 0));
        vecs.push_back(mk(1, 8'h43, 0, 0, 0,  1, 0, 0, 8'h22, 3, 0, 0));
        vecs.push_back(mk(1, 8'h44, 0, 0, 0,  1, 1, 0, 8'h22, 4, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h41, 3, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1,  0, 0, 0, 8'h41, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h41, 0, 0, 0));
        // Short frame with frame_done on the last write moves pointers to 2.
        vecs.push_back(mk(1, 8'h55, 0, 0, 0,  1, 0, 0, 8'h41, 1, 0, 0));
        vecs.push_back(mk(1, 8'h66, 1, 0, 0,  1, 1, 0, 8'h41, 2, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h55, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h66, 0, 0, 0));
        // Full frame across the pointer wrap.
        vecs.push_back(mk(1, 8'h81, 0, 0, 0,  1, 0, 0, 8'h66, 1, 0, 0));
        vecs.push_back(mk(1, 8'h82, 0, 0, 0,  1, 0, 0, 8'h66, 2, 0, 0));
        vecs.push_back(mk(1, 8'h83, 0, 0, 0,  1, 0, 0, 8'h66, 3, 0, 0));
        vecs.push_back(mk(1, 8'h84, 0, 0, 0,  1, 1, 0, 8'h66, 4, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h81, 3, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h82, 2, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h83, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 8'h84, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h84, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].wr_req, vecs[i].wr_data, vecs[i].frame_done,
                           vecs[i].rd_en, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].ack, vecs[i].fr, vecs[i].rv,
                      vecs[i].rdat, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
